// File: rtl/vga_screen_reader.sv
// vga_screen_reader
//   Scans the screen region of the data RAM and drives a 640x480@60 Hz VGA
//   output. Each RAM word is one RGB332 cell covering CELL_PX x CELL_PX
//   display pixels.
//
// Ports
//   CLK_50        50 MHz video clock (only clock)
//   resetN        synchronous active-low reset
//   addr_screen   cell index into the screen region (combinational from counters)
//   rdata_screen  RAM word for addr_screen, one CLK_50 edge after the address
//   vga_r/g/b     4-bit pixel colour, zero outside the visible area
//   vga_hs/vs     active-low sync
//   vga_de        high during visible pixels
//   frame_start   one-cycle pulse after pixel (0,0) is registered
module vga_screen_reader #(
  parameter int WIDTH          = 8,
  parameter int REGISTER_COUNT = 2048,
  parameter int CELL_PX        = 16,
  parameter int COLS           = 40,
  parameter int ROWS           = 30
) (
  input  logic                              CLK_50,
  input  logic                              resetN,
  output logic [$clog2(REGISTER_COUNT)-1:0] addr_screen,
  input  logic [WIDTH-1:0]                  rdata_screen,
  output logic [3:0]                        vga_r,
  output logic [3:0]                        vga_g,
  output logic [3:0]                        vga_b,
  output logic                              vga_hs,
  output logic                              vga_vs,
  output logic                              vga_de,
  output logic                              frame_start
);

  localparam int AW  = $clog2(REGISTER_COUNT);
  localparam int CSH = $clog2(CELL_PX);

  localparam logic [9:0] H_VIS   = 10'd640;
  localparam logic [9:0] H_SYNC0 = 10'd656;
  localparam logic [9:0] H_SYNC1 = 10'd751;
  localparam logic [9:0] H_LAST  = 10'd799;
  localparam logic [9:0] V_VIS   = 10'd480;
  localparam logic [9:0] V_SYNC0 = 10'd490;
  localparam logic [9:0] V_SYNC1 = 10'd491;
  localparam logic [9:0] V_LAST  = 10'd524;

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       visible;
  logic [7:0] d;

  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign d       = rdata_screen[7:0];

  // Address is held for both CLK_50 cycles of a pixel, so the RAM samples
  // it on the intermediate edge and the word is ready by the next pix_en edge.
  assign addr_screen = visible
    ? (AW'(v_cnt >> CSH) * AW'(COLS) + AW'(h_cnt >> CSH))
    : '0;

  always_ff @(posedge CLK_50) begin
    if (!resetN) begin
      pix_en      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      // Single CLK_50 pulse: only set on the pix_en edge registering (0,0).
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        // Outputs describe the pre-edge counter position, so sync, de and
        // colour share one pixel period of latency.
        vga_de <= visible;
        vga_hs <= !((h_cnt >= H_SYNC0) && (h_cnt <= H_SYNC1));
        vga_vs <= !((v_cnt >= V_SYNC0) && (v_cnt <= V_SYNC1));
        if (visible) begin
          vga_r <= {d[7:5], d[7]};
          vga_g <= {d[4:2], d[4]};
          vga_b <= {d[1:0], d[1:0]};
        end else begin
          vga_r <= '0;
          vga_g <= '0;
          vga_b <= '0;
        end
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_screen_reader.sv
module tb_vga_screen_reader;

  localparam int N_PIX = 800 * 525;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] addr_screen;
  logic [7:0]  rdata_screen;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, frame_start;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:2047];

  // Reference model: pixel-index view of the raster.
  int cidx = 0;   // pixel the counters point at
  int oidx = -1;  // pixel currently shown on the outputs, -1 = reset state
  bit ph   = 0;   // next CLK_50 edge is a pixel edge
  bit fs_e = 0;

  always #5 clk = ~clk;

  vga_screen_reader dut (
    .CLK_50      (clk),
    .resetN      (resetN),
    .addr_screen (addr_screen),
    .rdata_screen(rdata_screen),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_de      (vga_de),
    .frame_start (frame_start)
  );

  // Synchronous-read RAM screen port.
  always @(posedge clk) rdata_screen <= mem[addr_screen];

  always @(posedge clk) begin
    if (!resetN) begin
      cidx = 0; oidx = -1; ph = 0; fs_e = 0;
    end else if (ph) begin
      oidx = cidx;
      fs_e = (cidx == 0);
      cidx = (cidx + 1) % N_PIX;
      ph   = 0;
    end else begin
      fs_e = 0;
      ph   = 1;
    end
  end

  function automatic int cell_of(input int idx);
    int h, v;
    h = idx % 800;
    v = idx / 800;
    if (h < 640 && v < 480) return (v / 16) * 40 + h / 16;
    return 0;
  endfunction

  function automatic logic [11:0] rgb_of(input int d);
    int r, g, b;
    r = ((d >> 5) & 7) * 2 + ((d >> 7) & 1);
    g = ((d >> 2) & 7) * 2 + ((d >> 4) & 1);
    b = (d & 3) * 5;
    return 12'(r * 256 + g * 16 + b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h (model pixel h=%0d v=%0d)",
               tag, $time, got, exp, (oidx < 0) ? -1 : oidx % 800,
               (oidx < 0) ? -1 : oidx / 800);
    end
  endtask

  task automatic check_cycle();
    logic [3:0]  sync_e;
    logic [11:0] rgb_e;
    int h, v;
    if (oidx < 0) begin
      sync_e = {1'b0, 1'b1, 1'b1, fs_e};
      rgb_e  = '0;
    end else begin
      h = oidx % 800;
      v = oidx / 800;
      sync_e = {(h < 640 && v < 480), !(h >= 656 && h <= 751),
                !(v >= 490 && v <= 491), fs_e};
      rgb_e  = (h < 640 && v < 480) ? rgb_of(int'(mem[cell_of(oidx)])) : 12'h0;
    end
    chk("sync", 32'({vga_de, vga_hs, vga_vs, frame_start}), 32'(sync_e));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(rgb_e));
    chk("addr", 32'(addr_screen), 32'(cell_of(cidx)));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  // Skip ahead to line nv by loading the DUT's line counter, keeping h.
  // Done when the next edge is the intermediate one, so the RAM sees the
  // new address before the next pixel is registered.
  task automatic jump(input int nv);
    int guard = 0;
    while (ph && guard < 4) begin
      tick(1);
      guard++;
    end
    force dut.v_cnt = 10'(nv);
    cidx = (cidx % 800) + nv * 800;
    #1 release dut.v_cnt;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    mem[2] = 8'h03;

    resetN = 1'b0;
    tick(5);
    resetN = 1'b1;
    // 17+ lines covers cell-row 1 (address 40 at line 16).
    tick(17 * 1600 + int'($urandom_range(0, 800)));

    jump(478);           // last visible lines, address 1199
    tick(3 * 1600);
    jump(488);           // vertical sync lines
    tick(4 * 1600);
    jump(523);           // frame wrap and frame_start
    tick(2 * 1600 + 400);

    jump(300);
    tick(int'($urandom_range(1, 1599)));
    resetN = 1'b0;
    mem[0] = 8'hFF;      // blanking must still read as black
    tick(1);
    resetN = 1'b1;
    tick(2 * 1600 + 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
